// File: rtl/branch_ckpt_stack.sv
// Branch checkpoint stack: hands out one-hot tags, snapshots recovery state per branch,
// resolves several branches per cycle and restores from the oldest mispredict.
module ckpt_entry #(
    parameter int NUM_CKPT  = 8,
    parameter int ARCH_REGS = 32,
    parameter int PHYS_REGS = 64,
    parameter int PREG_W    = 6,
    parameter int ROB_W     = 5,
    parameter int LSQ_W     = 4,
    parameter int ADDR_W    = 32
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        wr,
    input  logic                        kill,
    input  logic [NUM_CKPT-1:0]         clr,
    input  logic [NUM_CKPT-1:0]         wr_dep,
    input  logic [ADDR_W-1:0]           wr_pc,
    input  logic [ROB_W-1:0]            wr_rob,
    input  logic [LSQ_W-1:0]            wr_lsq,
    input  logic [ARCH_REGS*PREG_W-1:0] wr_map,
    input  logic [PHYS_REGS-1:0]        wr_fl,
    input  logic [PHYS_REGS-1:0]        retire_freed,
    output logic                        valid,
    output logic [NUM_CKPT-1:0]         dep,
    output logic [ADDR_W-1:0]           pc,
    output logic [ROB_W-1:0]            rob,
    output logic [LSQ_W-1:0]            lsq,
    output logic [ARCH_REGS*PREG_W-1:0] map,
    output logic [PHYS_REGS-1:0]        fl
);
    // Write only targets an invalid entry and kill only valid ones, so they never collide.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            valid <= 1'b0;
            dep   <= '0;
            pc    <= '0;
            rob   <= '0;
            lsq   <= '0;
            map   <= '0;
            fl    <= '0;
        end else if (wr) begin
            valid <= 1'b1;
            dep   <= wr_dep;
            pc    <= wr_pc;
            rob   <= wr_rob;
            lsq   <= wr_lsq;
            map   <= wr_map;
            fl    <= wr_fl | retire_freed;
        end else if (kill) begin
            valid <= 1'b0;
            dep   <= '0;
        end else if (valid) begin
            dep <= dep & ~clr;
            fl  <= fl | retire_freed;
        end
    end
endmodule

module branch_ckpt_stack #(
    parameter int NUM_CKPT    = 8,
    parameter int NUM_RESOLVE = 2,
    parameter int ARCH_REGS   = 32,
    parameter int PHYS_REGS   = 64,
    parameter int PREG_W      = 6,
    parameter int ROB_W       = 5,
    parameter int LSQ_W       = 4,
    parameter int ADDR_W      = 32,
    localparam int CNT_W      = $clog2(NUM_CKPT+1)
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          alloc_req,
    input  logic [ADDR_W-1:0]             alloc_fallthrough_pc,
    input  logic [ROB_W-1:0]              alloc_rob_tail,
    input  logic [LSQ_W-1:0]              alloc_lsq_tail,
    input  logic [ARCH_REGS*PREG_W-1:0]   alloc_map_table,
    input  logic [PHYS_REGS-1:0]          alloc_free_list,
    output logic                          alloc_gnt,
    output logic [NUM_CKPT-1:0]           alloc_tag,
    output logic [NUM_CKPT-1:0]           valid_mask,
    output logic [CNT_W-1:0]              free_count,
    input  logic [PHYS_REGS-1:0]          retire_freed,
    input  logic [NUM_RESOLVE-1:0]        res_valid,
    input  logic [NUM_RESOLVE*NUM_CKPT-1:0] res_tag,
    input  logic [NUM_RESOLVE-1:0]        res_mispred,
    input  logic [NUM_RESOLVE-1:0]        res_taken,
    input  logic [NUM_RESOLVE*ADDR_W-1:0] res_target,
    output logic                          restore_valid,
    output logic [ADDR_W-1:0]             restore_pc,
    output logic [ROB_W-1:0]              restore_rob_tail,
    output logic [LSQ_W-1:0]              restore_lsq_tail,
    output logic [ARCH_REGS*PREG_W-1:0]   restore_map_table,
    output logic [PHYS_REGS-1:0]          restore_free_list,
    output logic [NUM_CKPT-1:0]           squash_mask,
    output logic [NUM_CKPT-1:0]           clear_mask
);
    logic [NUM_CKPT-1:0]                        valid;
    logic [NUM_CKPT-1:0][NUM_CKPT-1:0]          dep;
    logic [NUM_CKPT-1:0][ADDR_W-1:0]            e_pc;
    logic [NUM_CKPT-1:0][ROB_W-1:0]             e_rob;
    logic [NUM_CKPT-1:0][LSQ_W-1:0]             e_lsq;
    logic [NUM_CKPT-1:0][ARCH_REGS*PREG_W-1:0]  e_map;
    logic [NUM_CKPT-1:0][PHYS_REGS-1:0]         e_fl;

    logic [NUM_RESOLVE-1:0] eff;
    logic [NUM_CKPT-1:0]    mis_tags, cor_tags, winner, squash, clear, kill;
    logic [NUM_CKPT-1:0]    free_oh, wr_oh, wr_dep, valid_n;
    logic [ADDR_W-1:0]      fall_pc, tgt;
    logic                   taken, found, gnt;
    logic [CNT_W-1:0]       free_cnt_q, free_cnt_d;

    genvar g;
    generate
        for (g = 0; g < NUM_CKPT; g++) begin : g_ent
            ckpt_entry #(
                .NUM_CKPT(NUM_CKPT), .ARCH_REGS(ARCH_REGS), .PHYS_REGS(PHYS_REGS),
                .PREG_W(PREG_W), .ROB_W(ROB_W), .LSQ_W(LSQ_W), .ADDR_W(ADDR_W)
            ) u_ent (
                .clock(clock), .reset(reset), .wr(wr_oh[g]), .kill(kill[g]), .clr(clear),
                .wr_dep(wr_dep), .wr_pc(alloc_fallthrough_pc), .wr_rob(alloc_rob_tail),
                .wr_lsq(alloc_lsq_tail), .wr_map(alloc_map_table), .wr_fl(alloc_free_list),
                .retire_freed(retire_freed), .valid(valid[g]), .dep(dep[g]), .pc(e_pc[g]),
                .rob(e_rob[g]), .lsq(e_lsq[g]), .map(e_map[g]), .fl(e_fl[g])
            );
        end
    endgenerate

    always_comb begin
        eff      = '0;
        mis_tags = '0;
        cor_tags = '0;
        for (int c = 0; c < NUM_RESOLVE; c++) begin
            eff[c] = res_valid[c] & (|(res_tag[c*NUM_CKPT +: NUM_CKPT] & valid));
            if (eff[c] && res_mispred[c])
                mis_tags = mis_tags | (res_tag[c*NUM_CKPT +: NUM_CKPT] & valid);
            else if (eff[c])
                cor_tags = cor_tags | (res_tag[c*NUM_CKPT +: NUM_CKPT] & valid);
        end
    end

    // Oldest mispredict: no other mispredicting tag among its older dependencies.
    always_comb begin
        winner = '0;
        for (int i = NUM_CKPT-1; i >= 0; i--)
            if (mis_tags[i] && ((dep[i] & mis_tags) == '0))
                winner = NUM_CKPT'(1) << i;
    end

    always_comb begin
        for (int i = 0; i < NUM_CKPT; i++)
            squash[i] = winner[i] | (valid[i] & (|(dep[i] & winner)));
        clear = cor_tags & ~squash;
        kill  = squash | clear;
    end

    always_comb begin
        fall_pc           = '0;
        restore_rob_tail  = '0;
        restore_lsq_tail  = '0;
        restore_map_table = '0;
        restore_free_list = '0;
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (winner[i]) begin
                fall_pc           = fall_pc | e_pc[i];
                restore_rob_tail  = restore_rob_tail | e_rob[i];
                restore_lsq_tail  = restore_lsq_tail | e_lsq[i];
                restore_map_table = restore_map_table | e_map[i];
                restore_free_list = restore_free_list | e_fl[i];
            end
        end
        taken = 1'b0;
        tgt   = '0;
        found = 1'b0;
        for (int c = 0; c < NUM_RESOLVE; c++) begin
            if (!found && eff[c] && res_mispred[c] &&
                ((res_tag[c*NUM_CKPT +: NUM_CKPT] & winner) != '0)) begin
                found = 1'b1;
                taken = res_taken[c];
                tgt   = res_target[c*ADDR_W +: ADDR_W];
            end
        end
        restore_pc = taken ? tgt : fall_pc;
    end

    always_comb begin
        free_oh = '0;
        for (int i = NUM_CKPT-1; i >= 0; i--)
            if (!valid[i]) free_oh = NUM_CKPT'(1) << i;
        gnt     = alloc_req & (free_cnt_q != '0) & ~(|winner) & ~reset;
        wr_oh   = gnt ? free_oh : '0;
        wr_dep  = valid & ~clear;
        valid_n = (valid & ~kill) | wr_oh;
        free_cnt_d = '0;
        for (int i = 0; i < NUM_CKPT; i++)
            if (!valid_n[i]) free_cnt_d = free_cnt_d + CNT_W'(1);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) free_cnt_q <= CNT_W'(NUM_CKPT);
        else       free_cnt_q <= free_cnt_d;
    end

    assign alloc_gnt     = gnt;
    assign alloc_tag     = wr_oh;
    assign valid_mask    = valid;
    assign free_count    = free_cnt_q;
    assign restore_valid = |winner;
    assign squash_mask   = squash;
    assign clear_mask    = clear;
endmodule

// File: tb/tb_branch_ckpt_stack.sv
// Bench for branch_ckpt_stack: directed scenarios plus random traffic, checked by a
// scoreboard fed from an age-ordered reference model.
module tb_branch_ckpt_stack;
    localparam int N = 4, R = 2, AR = 32, PR = 64, PW = 6, RW = 5, LW = 4, AW = 32;
    localparam int CW = $clog2(N+1);

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic              alloc_req;
    logic [AW-1:0]     alloc_fallthrough_pc;
    logic [RW-1:0]     alloc_rob_tail;
    logic [LW-1:0]     alloc_lsq_tail;
    logic [AR*PW-1:0]  alloc_map_table;
    logic [PR-1:0]     alloc_free_list;
    logic              alloc_gnt;
    logic [N-1:0]      alloc_tag;
    logic [N-1:0]      valid_mask;
    logic [CW-1:0]     free_count;
    logic [PR-1:0]     retire_freed;
    logic [R-1:0]      res_valid, res_mispred, res_taken;
    logic [R*N-1:0]    res_tag;
    logic [R*AW-1:0]   res_target;
    logic              restore_valid;
    logic [AW-1:0]     restore_pc;
    logic [RW-1:0]     restore_rob_tail;
    logic [LW-1:0]     restore_lsq_tail;
    logic [AR*PW-1:0]  restore_map_table;
    logic [PR-1:0]     restore_free_list;
    logic [N-1:0]      squash_mask, clear_mask;

    branch_ckpt_stack #(.NUM_CKPT(N), .NUM_RESOLVE(R)) dut (
        .clock(clock), .reset(reset), .alloc_req(alloc_req),
        .alloc_fallthrough_pc(alloc_fallthrough_pc), .alloc_rob_tail(alloc_rob_tail),
        .alloc_lsq_tail(alloc_lsq_tail), .alloc_map_table(alloc_map_table),
        .alloc_free_list(alloc_free_list), .alloc_gnt(alloc_gnt), .alloc_tag(alloc_tag),
        .valid_mask(valid_mask), .free_count(free_count), .retire_freed(retire_freed),
        .res_valid(res_valid), .res_tag(res_tag), .res_mispred(res_mispred),
        .res_taken(res_taken), .res_target(res_target), .restore_valid(restore_valid),
        .restore_pc(restore_pc), .restore_rob_tail(restore_rob_tail),
        .restore_lsq_tail(restore_lsq_tail), .restore_map_table(restore_map_table),
        .restore_free_list(restore_free_list), .squash_mask(squash_mask),
        .clear_mask(clear_mask)
    );

    typedef struct packed {
        logic             req;
        logic [AW-1:0]    pc;
        logic [RW-1:0]    rob;
        logic [LW-1:0]    lsq;
        logic [AR*PW-1:0] map;
        logic [PR-1:0]    fl;
        logic [PR-1:0]    ret;
        logic [R-1:0]     rv, rm, rt;
        logic [R*N-1:0]   tag;
        logic [R*AW-1:0]  tgt;
    } stim_t;

    typedef struct packed {
        logic             gnt;
        logic [N-1:0]     tag, vmask;
        logic [CW-1:0]    fc;
        logic             rv;
        logic [AW-1:0]    pc;
        logic [RW-1:0]    rob;
        logic [LW-1:0]    lsq;
        logic [AR*PW-1:0] map;
        logic [PR-1:0]    fl;
        logic [N-1:0]     sq, clr;
    } exp_t;

    exp_t q[$];
    int tests = 0, fails = 0;

    // Reference model: live tags kept oldest-first; snapshots indexed by tag.
    int               order[$];
    logic [AW-1:0]    m_pc[N];
    logic [RW-1:0]    m_rob[N];
    logic [LW-1:0]    m_lsq[N];
    logic [AR*PW-1:0] m_map[N];
    logic [PR-1:0]    m_fl[N];

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int oh_idx(input logic [N-1:0] v);
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return -1;
    endfunction

    function automatic bit is_live(input int t);
        foreach (order[k]) if (order[k] == t) return 1'b1;
        return 1'b0;
    endfunction

    function automatic stim_t idle();
        stim_t s;
        s = '0;
        return s;
    endfunction

    function automatic stim_t rand_alloc(input stim_t si);
        stim_t s;
        s = si;
        s.req = 1'b1;
        s.pc  = $urandom;
        s.rob = RW'($urandom);
        s.lsq = LW'($urandom);
        s.map = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        s.fl  = {$urandom, $urandom};
        return s;
    endfunction

    task automatic apply(input stim_t s);
        alloc_req = s.req;  alloc_fallthrough_pc = s.pc;  alloc_rob_tail = s.rob;
        alloc_lsq_tail = s.lsq;  alloc_map_table = s.map;  alloc_free_list = s.fl;
        retire_freed = s.ret;  res_valid = s.rv;  res_mispred = s.rm;  res_taken = s.rt;
        res_tag = s.tag;  res_target = s.tgt;
    endtask

    task automatic model_step();
        exp_t e;
        bit mis[N];
        bit cor[N];
        int wch[N];
        int win, t, nt;
        int keep[$];
        logic [N-1:0] sq, cl;
        e = '0;
        foreach (order[k]) e.vmask[order[k]] = 1'b1;
        e.fc = CW'(N - order.size());
        for (int i = 0; i < N; i++) begin mis[i] = 0; cor[i] = 0; wch[i] = 0; end
        for (int c = 0; c < R; c++) begin
            t = oh_idx(res_tag[c*N +: N]);
            if (res_valid[c] && t >= 0 && is_live(t)) begin
                if (res_mispred[c]) begin
                    if (!mis[t]) begin mis[t] = 1; wch[t] = c; end
                end else cor[t] = 1;
            end
        end
        win = -1;
        for (int k = 0; k < order.size(); k++) if (mis[order[k]]) begin win = k; break; end
        sq = '0;
        if (win >= 0) begin
            t    = order[win];
            e.rv = 1'b1;
            e.pc = res_taken[wch[t]] ? res_target[wch[t]*AW +: AW] : m_pc[t];
            e.rob = m_rob[t];  e.lsq = m_lsq[t];  e.map = m_map[t];  e.fl = m_fl[t];
            for (int k = win; k < order.size(); k++) sq[order[k]] = 1'b1;
        end
        cl = '0;
        for (int i = 0; i < N; i++) if (cor[i] && !sq[i]) cl[i] = 1'b1;
        e.sq = sq;
        e.clr = cl;
        e.gnt = alloc_req && (order.size() < N) && (win < 0);
        nt = -1;
        if (e.gnt) begin
            for (int i = N-1; i >= 0; i--) if (!is_live(i)) nt = i;
            e.tag[nt] = 1'b1;
        end
        foreach (order[k]) begin
            if (!sq[order[k]] && !cl[order[k]]) begin
                keep.push_back(order[k]);
                m_fl[order[k]] = m_fl[order[k]] | retire_freed;
            end
        end
        order = keep;
        if (e.gnt) begin
            order.push_back(nt);
            m_pc[nt] = alloc_fallthrough_pc;  m_rob[nt] = alloc_rob_tail;
            m_lsq[nt] = alloc_lsq_tail;  m_map[nt] = alloc_map_table;
            m_fl[nt] = alloc_free_list | retire_freed;
        end
        q.push_back(e);
    endtask

    task automatic drive(input stim_t s);
        @(posedge clock); #1;
        apply(s);
        model_step();
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        reset = 1'b1;
        apply(idle());
        order.delete();
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // Monitor: one expected response per driven cycle, compared at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clock);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("gnt", alloc_gnt, e.gnt);
                chk("tag", alloc_tag, e.tag);
                chk("valid_mask", valid_mask, e.vmask);
                chk("free_count", free_count, e.fc);
                chk("restore_valid", restore_valid, e.rv);
                chk("squash_mask", squash_mask, e.sq);
                chk("clear_mask", clear_mask, e.clr);
                if (e.rv) begin
                    chk("restore_pc", restore_pc, e.pc);
                    chk("restore_rob", restore_rob_tail, e.rob);
                    chk("restore_lsq", restore_lsq_tail, e.lsq);
                    chk("restore_map", restore_map_table, e.map);
                    chk("restore_fl", restore_free_list, e.fl);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        stim_t s;
        reset = 1'b1;
        apply(idle());
        repeat (2) @(posedge clock);
        #1 reset = 1'b0;
        #1;
        chk("rst_valid_mask", valid_mask, 0);
        chk("rst_free_count", free_count, N);
        chk("rst_restore", restore_valid, 0);

        // Fill all four entries, then one more request must be refused.
        for (int i = 0; i < 5; i++) begin
            drive(rand_alloc(idle()));
            #1;
            chk("fill_gnt", alloc_gnt, (i < 4) ? 1 : 0);
            chk("fill_tag", alloc_tag, (i < 4) ? (1 << i) : 0);
        end
        drive(idle());
        #1 chk("full_count", free_count, 0);

        // Correct resolve of the older branch clears its bit.
        do_reset();
        drive(rand_alloc(idle()));
        drive(rand_alloc(idle()));
        s = idle(); s.rv = 2'b01; s.tag = {4'b0000, 4'b0001};
        drive(s);
        #1 chk("clr_a", clear_mask, 4'b0001);
        drive(idle());
        #1 chk("clr_vmask", valid_mask, 4'b0010);
        chk("clr_count", free_count, 3);

        // Taken mispredict of the middle branch.
        do_reset();
        for (int i = 0; i < 3; i++) begin
            s = rand_alloc(idle()); s.rob = RW'(i + 1);
            drive(s);
        end
        s = idle(); s.rv = 2'b01; s.rm = 2'b01; s.rt = 2'b01;
        s.tag = {4'b0000, 4'b0010}; s.tgt = {32'h0, 32'h200};
        drive(s);
        #1 chk("misb_rv", restore_valid, 1);
        chk("misb_pc", restore_pc, 32'h200);
        chk("misb_sq", squash_mask, 4'b0110);
        chk("misb_rob", restore_rob_tail, 2);
        drive(idle());
        #1 chk("misb_vmask", valid_mask, 4'b0001);

        // Two mispredicts in one cycle: the oldest wins.
        do_reset();
        s = rand_alloc(idle()); s.pc = 32'h104;
        drive(s);
        drive(rand_alloc(idle()));
        drive(rand_alloc(idle()));
        s = idle(); s.rv = 2'b11; s.rm = 2'b11; s.rt = 2'b01;
        s.tag = {4'b0001, 4'b0100}; s.tgt = {32'h900, 32'h800};
        drive(s);
        #1 chk("dual_pc", restore_pc, 32'h104);
        chk("dual_sq", squash_mask, 4'b0111);
        chk("dual_clr", clear_mask, 4'b0000);

        // Retired registers accumulate into a live snapshot.
        do_reset();
        s = rand_alloc(idle()); s.fl = '0;
        drive(s);
        s = idle(); s.ret = 64'h20;
        drive(s);
        drive(s);
        s = idle(); s.rv = 2'b01; s.rm = 2'b01; s.tag = {4'b0000, 4'b0001};
        drive(s);
        #1 chk("fl_bit5", restore_free_list, 64'h20);

        // Reset in the middle of a restore.
        do_reset();
        drive(rand_alloc(idle()));
        @(posedge clock); #1;
        s = idle(); s.req = 1'b1; s.rv = 2'b01; s.rm = 2'b01; s.tag = {4'b0000, 4'b0001};
        apply(s);
        #1 chk("mid_rv_before", restore_valid, 1);
        reset = 1'b1;
        order.delete();
        #1;
        chk("mid_rv", restore_valid, 0);
        chk("mid_sq", squash_mask, 0);
        chk("mid_clr", clear_mask, 0);
        chk("mid_gnt", alloc_gnt, 0);
        chk("mid_tag", alloc_tag, 0);
        chk("mid_vmask", valid_mask, 0);
        chk("mid_count", free_count, N);
        @(posedge clock); #1;
        reset = 1'b0;
        apply(idle());
        drive(idle());

        // Random traffic.
        for (int n = 0; n < 3000; n++) begin
            s = idle();
            if ($urandom_range(0, 9) < 6) s = rand_alloc(s);
            s.ret = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
            for (int c = 0; c < R; c++) begin
                s.rv[c] = ($urandom_range(0, 1) == 1);
                s.rm[c] = ($urandom_range(0, 9) < 2);
                s.rt[c] = ($urandom_range(0, 1) == 1);
                s.tag[c*N +: N] = N'(1) << $urandom_range(0, N-1);
                s.tgt[c*AW +: AW] = $urandom;
            end
            drive(s);
            if (n % 500 == 499) do_reset();
        end
        drive(idle());
        @(negedge clock); #1;
        chk("scoreboard_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
